digit_entry_ctrl: RTL

// Upstream of the 4-digit 7-segment scan driver. Turns button presses into a 4-digit
// BCD entry with a cursor, and drives the driver's dataBus/dot/sel inputs directly.

---
 rtl/digit_entry_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl
//   Button-driven 4-digit BCD entry with a cursor. The block feeds the 4-digit
//   7-segment scan driver directly through dataBus/dot/sel.
//   IDLE   : driver shows dashes (sel=1).
//   EDIT   : digits shown and the cursor digit blinks; inc/dec/left/right/clr/ok act.
//   LOCKED : confirmed value shown steadily; ok resumes editing, clr abandons.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   btn_inc    increment cursor digit (debounced level)
//   btn_dec    decrement cursor digit
//   btn_left   cursor toward dataBus[15:12]
//   btn_right  cursor toward dataBus[3:0]
//   btn_ok     confirm / resume
//   btn_clr    clear / abandon
//   dataBus    four display codes, nibble i = digit i (4'hB = blank)
//   dot        decimal point position = cursor index
//   sel        1 = driver shows dashes, 0 = driver shows dataBus
//   value      last confirmed BCD value
//   done       one-cycle pulse when a value is confirmed
module digit_entry_ctrl #(
    parameter int BLINK_HALF = 95,
    parameter int TIMEOUT    = 1900
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_ok,
    input  logic        btn_clr,
    output logic [15:0] dataBus,
    output logic [1:0]  dot,
    output logic        sel,
    output logic [15:0] value,
    output logic        done
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [3:0]    BLANK      = 4'hB;

    // Bit positions in the button vectors; higher index = higher priority.
    localparam int A_RIGHT = 0;
    localparam int A_LEFT  = 1;
    localparam int A_DEC   = 2;
    localparam int A_INC   = 3;
    localparam int A_OK    = 4;
    localparam int A_CLR   = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      btn_now, btn_q, rise, act;
    logic [3:0][3:0] digits_q, digits_d, disp;
    logic [1:0]      cursor_q, cursor_d;
    logic            blink_on_q, blink_on_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]     value_q, value_d;
    logic            done_q, done_d;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    assign btn_now = {btn_clr, btn_ok, btn_inc, btn_dec, btn_left, btn_right};
    assign rise    = btn_now & ~btn_q;

    // One-hot action: highest-priority rising edge wins, the rest are dropped.
    always_comb begin
        act = '0;
        if      (rise[A_CLR])   act[A_CLR]   = 1'b1;
        else if (rise[A_OK])    act[A_OK]    = 1'b1;
        else if (rise[A_INC])   act[A_INC]   = 1'b1;
        else if (rise[A_DEC])   act[A_DEC]   = 1'b1;
        else if (rise[A_LEFT])  act[A_LEFT]  = 1'b1;
        else if (rise[A_RIGHT]) act[A_RIGHT] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            btn_q       <= '0;
            digits_q    <= '0;
            cursor_q    <= '0;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= '0;
            to_cnt_q    <= '0;
            value_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_now;
            digits_q    <= digits_d;
            cursor_q    <= cursor_d;
            blink_on_q  <= blink_on_d;
            blink_cnt_q <= blink_cnt_d;
            to_cnt_q    <= to_cnt_d;
            value_q     <= value_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        cursor_d    = cursor_q;
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q;
        to_cnt_d    = to_cnt_q;
        value_d     = value_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The waking press only opens the editor; it is not applied.
                if (act[A_INC] | act[A_DEC] | act[A_LEFT] | act[A_RIGHT]) begin
                    state_d     = S_EDIT;
                    digits_d    = '0;
                    cursor_d    = '0;
                    blink_on_d  = 1'b1;
                    blink_cnt_d = '0;
                    to_cnt_d    = '0;
                end
            end

            S_EDIT: begin
                if (|act) begin
                    // Any accepted press restarts the timeout and shows the digit solid.
                    to_cnt_d    = '0;
                    blink_on_d  = 1'b1;
                    blink_cnt_d = '0;
                    if (act[A_CLR]) begin
                        digits_d = '0;
                    end else if (act[A_OK]) begin
                        value_d = digits_q;
                        done_d  = 1'b1;
                        state_d = S_LOCKED;
                    end else if (act[A_INC]) begin
                        digits_d[cursor_q] = bcd_inc(digits_q[cursor_q]);
                    end else if (act[A_DEC]) begin
                        digits_d[cursor_q] = bcd_dec(digits_q[cursor_q]);
                    end else if (act[A_LEFT]) begin
                        cursor_d = cursor_q + 2'd1;
                    end else begin
                        cursor_d = cursor_q - 2'd1;
                    end
                end else begin
                    if (to_cnt_q == TO_LAST) state_d = S_IDLE;
                    else                     to_cnt_d = to_cnt_q + TW'(1);

                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_on_d  = ~blink_on_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
            end

            S_LOCKED: begin
                if (act[A_OK]) begin
                    state_d     = S_EDIT;
                    blink_on_d  = 1'b1;
                    blink_cnt_d = '0;
                    to_cnt_d    = '0;
                end else if (act[A_CLR]) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: decoded from registers only, so they trail the press by one cycle.
    always_comb begin
        disp = digits_q;
        if (state_q == S_EDIT && !blink_on_q) disp[cursor_q] = BLANK;
        dataBus = disp;
        dot     = cursor_q;
        sel     = (state_q == S_IDLE);
        value   = value_q;
        done    = done_q;
    end

endmodule
